// File: rtl/clock_ctrl_pkg.sv
// Mode encoding shared between the set-button controller and the timekeeping datapath.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_SEC  = 2'b01,
    MODE_MIN  = 2'b10,
    MODE_HOUR = 2'b11
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_RUN: return MODE_SEC;
      MODE_SEC: return MODE_MIN;
      MODE_MIN: return MODE_HOUR;
      default:  return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer and stability debouncer for one raw button, with registered
// rise and any-edge strobes that coincide with the first cycle of the new level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic toggle
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      toggle <= 1'b0;
    end else begin
      sync1  <= btn;
      sync2  <= sync1;
      rise   <= 1'b0;
      toggle <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This cycle is the DEBOUNCE_CYC-th consecutive mismatch.
        level  <= sync2;
        cnt    <= '0;
        rise   <= sync2;
        toggle <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock setting controller: mode cycling, plus/minus strobes with auto-repeat,
// and an inactivity timeout that drops back to run mode.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 5_000_000,
  parameter int unsigned TIMEOUT_CYC      = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_plus,
  input  logic       btn_minus,
  output logic [1:0] mode,
  output logic       plus_pulse,
  output logic       minus_pulse,
  output logic       setting
);

  localparam int unsigned REP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                         : REPEAT_RATE_CYC;
  localparam int unsigned REP_W = $clog2(REP_MAX + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

  logic md_lvl, md_rise, md_tog;
  logic p_lvl,  p_rise,  p_tog;
  logic n_lvl,  n_rise,  n_tog;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .btn(btn_mode), .level(md_lvl), .rise(md_rise), .toggle(md_tog)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_plus (
    .clk(clk), .rst_n(rst_n), .btn(btn_plus), .level(p_lvl), .rise(p_rise), .toggle(p_tog)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_minus (
    .clk(clk), .rst_n(rst_n), .btn(btn_minus), .level(n_lvl), .rise(n_rise), .toggle(n_tog)
  );

  mode_t            state, mode_nxt;
  logic             timeout, mode_step, mode_chg;
  logic [TO_W-1:0]  to_cnt;
  logic             p_act, p_first, n_act, n_first;
  logic [REP_W-1:0] p_cnt, n_cnt, p_lim, n_lim;

  assign mode = state;

  always_comb begin
    mode_step = md_rise && md_lvl;
    timeout   = (state != MODE_RUN) && (to_cnt == TO_LAST);
    mode_nxt  = state;
    // Timeout takes priority so a coincident mode press still lands in run.
    if (timeout)        mode_nxt = MODE_RUN;
    else if (mode_step) mode_nxt = next_mode(state);
    mode_chg = timeout || mode_step;
    p_lim    = p_first ? DELAY_LAST : RATE_LAST;
    n_lim    = n_first ? DELAY_LAST : RATE_LAST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MODE_RUN;
      setting     <= 1'b0;
      plus_pulse  <= 1'b0;
      minus_pulse <= 1'b0;
      to_cnt      <= '0;
      p_act       <= 1'b0;
      p_first     <= 1'b0;
      p_cnt       <= '0;
      n_act       <= 1'b0;
      n_first     <= 1'b0;
      n_cnt       <= '0;
    end else begin
      state       <= mode_nxt;
      setting     <= (mode_nxt != MODE_RUN);
      plus_pulse  <= 1'b0;
      minus_pulse <= 1'b0;

      if (state == MODE_RUN || timeout || md_tog || p_tog || n_tog || plus_pulse || minus_pulse)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TO_W'(1);

      // Dropping the active flags disarms held buttons; only a fresh rise re-arms.
      if (state == MODE_RUN || mode_chg || (p_lvl && n_lvl)) begin
        p_act   <= 1'b0;
        p_first <= 1'b0;
        p_cnt   <= '0;
        n_act   <= 1'b0;
        n_first <= 1'b0;
        n_cnt   <= '0;
      end else begin
        if (p_rise) begin
          plus_pulse <= 1'b1;
          p_act      <= 1'b1;
          p_first    <= 1'b1;
          p_cnt      <= '0;
        end else if (p_act && p_lvl) begin
          if (p_cnt == p_lim) begin
            plus_pulse <= 1'b1;
            p_first    <= 1'b0;
            p_cnt      <= '0;
          end else begin
            p_cnt <= p_cnt + REP_W'(1);
          end
        end else begin
          p_act   <= 1'b0;
          p_first <= 1'b0;
          p_cnt   <= '0;
        end

        if (n_rise) begin
          minus_pulse <= 1'b1;
          n_act       <= 1'b1;
          n_first     <= 1'b1;
          n_cnt       <= '0;
        end else if (n_act && n_lvl) begin
          if (n_cnt == n_lim) begin
            minus_pulse <= 1'b1;
            n_first     <= 1'b0;
            n_cnt       <= '0;
          end else begin
            n_cnt <= n_cnt + REP_W'(1);
          end
        end else begin
          n_act   <= 1'b0;
          n_first <= 1'b0;
          n_cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/repeat/timeout parameters.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_plus = 1'b0;
  logic       btn_minus = 1'b0;
  logic [1:0] mode;
  logic       plus_pulse;
  logic       minus_pulse;
  logic       setting;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .DEBOUNCE_CYC(4),
    .REPEAT_DELAY_CYC(20),
    .REPEAT_RATE_CYC(5),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_mode(btn_mode),
    .btn_plus(btn_plus),
    .btn_minus(btn_minus),
    .mode(mode),
    .plus_pulse(plus_pulse),
    .minus_pulse(minus_pulse),
    .setting(setting)
  );

  // Edges are counted from the moment a raw input is driven; sampling is 1 ns after each edge.
  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 10-cycle mode press plus 10-cycle gap; returns 20 edges after the raw rise.
  task automatic press_mode(input logic [1:0] exp_old, input logic [1:0] exp_new, input string name);
    bit quiet = 1'b1;
    btn_mode = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick(1);
      if (plus_pulse || minus_pulse) quiet = 1'b0;
      if (e == 6) begin
        checks++;
        if (mode !== exp_old) begin
          errors++;
          $display("FAIL %s_before: mode=%b expected %b", name, mode, exp_old);
        end
      end
      if (e == 7) begin
        checks++;
        if (mode !== exp_new) begin
          errors++;
          $display("FAIL %s_after: mode=%b expected %b", name, mode, exp_new);
        end
        checks++;
        if (setting !== (exp_new != 2'b00)) begin
          errors++;
          $display("FAIL %s_setting: setting=%b expected %b", name, setting, exp_new != 2'b00);
        end
      end
      if (e == 10) btn_mode = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL %s_quiet: pulse seen during mode press, expected none", name);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    tick(3);
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode: mode=%b expected 00", mode); end
    checks++;
    if (plus_pulse !== 1'b0) begin errors++; $display("FAIL reset_plus: got %b expected 0", plus_pulse); end
    checks++;
    if (minus_pulse !== 1'b0) begin errors++; $display("FAIL reset_minus: got %b expected 0", minus_pulse); end
    checks++;
    if (setting !== 1'b0) begin errors++; $display("FAIL reset_setting: got %b expected 0", setting); end
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL reset_release_mode: mode=%b expected 00", mode); end
  endtask

  task automatic test_mode_cycle;
    press_mode(2'b00, 2'b01, "cycle_sec");
    press_mode(2'b01, 2'b10, "cycle_min");
    press_mode(2'b10, 2'b11, "cycle_hour");
    press_mode(2'b11, 2'b00, "cycle_run");
  endtask

  task automatic test_repeat;
    logic exp;
    press_mode(2'b00, 2'b01, "repeat_enter");
    btn_plus = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      tick(1);
      if (e == 45) btn_plus = 1'b0;
      exp = (e inside {7, 27, 32, 37, 42, 47});
      checks++;
      if (plus_pulse !== exp) begin
        errors++;
        $display("FAIL repeat_plus@%0d: plus_pulse=%b expected %b", e, plus_pulse, exp);
      end
      checks++;
      if (minus_pulse !== 1'b0) begin
        errors++;
        $display("FAIL repeat_minus@%0d: minus_pulse=%b expected 0", e, minus_pulse);
      end
    end
  endtask

  // Timeout lands 117 edges after the last mode press's raw rise (its debounced fall clears the counter at +17).
  task automatic test_glitch;
    bit quiet = 1'b1;
    press_mode(2'b01, 2'b10, "glitch_enter");
    tick(5);
    btn_minus = 1'b1;
    for (int e = 26; e <= 117; e++) begin
      tick(1);
      if (e == 28) btn_minus = 1'b0;
      if (plus_pulse || minus_pulse) quiet = 1'b0;
      if (e == 116) begin
        checks++;
        if (mode !== 2'b10) begin errors++; $display("FAIL glitch_hold: mode=%b expected 10", mode); end
      end
    end
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL glitch_timeout: mode=%b expected 00", mode); end
    checks++;
    if (!quiet) begin errors++; $display("FAIL glitch_pulse: pulse seen, expected none"); end
  endtask

  task automatic test_both;
    logic exp;
    press_mode(2'b00, 2'b01, "both_enter");
    btn_plus = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      tick(1);
      if (e == 10) btn_minus = 1'b1;
      if (e == 50) begin
        btn_plus  = 1'b0;
        btn_minus = 1'b0;
      end
      exp = (e == 7);
      checks++;
      if (plus_pulse !== exp) begin
        errors++;
        $display("FAIL both_plus@%0d: plus_pulse=%b expected %b", e, plus_pulse, exp);
      end
      checks++;
      if (minus_pulse !== 1'b0) begin
        errors++;
        $display("FAIL both_minus@%0d: minus_pulse=%b expected 0", e, minus_pulse);
      end
    end
  endtask

  task automatic test_timeout;
    bit quiet = 1'b1;
    press_mode(2'b01, 2'b10, "timeout_min");
    press_mode(2'b10, 2'b11, "timeout_hour");
    for (int e = 21; e <= 117; e++) begin
      tick(1);
      if (plus_pulse || minus_pulse) quiet = 1'b0;
      if (e == 116) begin
        checks++;
        if (mode !== 2'b11) begin errors++; $display("FAIL timeout_hold: mode=%b expected 11", mode); end
      end
    end
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL timeout_run: mode=%b expected 00", mode); end
    checks++;
    if (setting !== 1'b0) begin errors++; $display("FAIL timeout_setting: setting=%b expected 0", setting); end
    checks++;
    if (!quiet) begin errors++; $display("FAIL timeout_pulse: pulse seen, expected none"); end
  endtask

  task automatic test_reset_mid_repeat;
    logic exp;
    bit quiet = 1'b1;
    press_mode(2'b00, 2'b01, "rst_enter");
    btn_plus = 1'b1;
    for (int e = 1; e <= 27; e++) begin
      tick(1);
      exp = (e == 7) || (e == 27);
      checks++;
      if (plus_pulse !== exp) begin
        errors++;
        $display("FAIL rst_repeat@%0d: plus_pulse=%b expected %b", e, plus_pulse, exp);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL rst_async_mode: mode=%b expected 00", mode); end
    checks++;
    if (plus_pulse !== 1'b0) begin errors++; $display("FAIL rst_async_plus: got %b expected 0", plus_pulse); end
    checks++;
    if (setting !== 1'b0) begin errors++; $display("FAIL rst_async_setting: got %b expected 0", setting); end
    tick(3);
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick(1);
      if (plus_pulse || minus_pulse) quiet = 1'b0;
    end
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL rst_run_mode: mode=%b expected 00", mode); end
    press_mode(2'b00, 2'b01, "rst_reenter");
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      if (plus_pulse || minus_pulse) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL rst_held_quiet: pulse seen while held, expected none"); end
    btn_plus = 1'b0;
    tick(10);
    btn_plus = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      exp = (e == 7);
      checks++;
      if (plus_pulse !== exp) begin
        errors++;
        $display("FAIL rst_fresh_press@%0d: plus_pulse=%b expected %b", e, plus_pulse, exp);
      end
    end
    btn_plus = 1'b0;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_repeat();
    test_glitch();
    test_both();
    test_timeout();
    test_reset_mid_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1);
  end

endmodule
